// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready request handshake,
// sized signed/unsigned loads, error reporting and fixed response latency.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_write_i                  1 = store, 0 = load
//   req_size_i                   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i               loads: 1 = zero-extend, 0 = sign-extend
//   addr_base_i, addr_offset_i   effective address = base + offset (wrapping)
//   wdata_i                      store data, low bytes used per size
//   resp_valid_o                 one-cycle response strobe
//   rdata_o                      extended load result, held between responses
//   resp_err_o                   00 ok, 01 misaligned, 10 out of range, 11 bad size
module data_mem_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int LATENCY   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [WORD_SIZE-1:0] addr_base_i,
    input  logic [WORD_SIZE-1:0] addr_offset_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    output logic                 resp_valid_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic [1:0]           resp_err_o
);
    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [7:0]          mem [MEM_SIZE];

    logic                accept;
    logic [WORD_SIZE-1:0] ea;
    logic [WORD_SIZE:0]  last;
    logic [1:0]          nb_m1;
    logic                misal;
    logic                oor;
    logic [1:0]          err;
    logic [31:0]         raw;
    logic [WORD_SIZE-1:0] ld;
    logic [WORD_SIZE-1:0] res_rdata;
    logic [WORD_SIZE-1:0] pend_rdata;
    logic [1:0]          pend_err;
    logic                wait_done;

    assign accept    = req_valid_i && req_ready_o && !rst_i;
    assign ea        = addr_base_i + addr_offset_i;
    assign wait_done = (state == WAIT) && (cnt == CW'(1));

    // Range check is done one bit wider so an access straddling
    // the top of the address space is not hidden by wrap-around.
    always_comb begin
        nb_m1 = 2'd0;
        misal = 1'b0;
        unique case (req_size_i)
            2'b00: nb_m1 = 2'd0;
            2'b01: begin
                nb_m1 = 2'd1;
                misal = ea[0];
            end
            2'b10: begin
                nb_m1 = 2'd3;
                misal = |ea[1:0];
            end
            default: nb_m1 = 2'd0;
        endcase
        last = {1'b0, ea} + {{(WORD_SIZE-1){1'b0}}, nb_m1};
        oor  = last >= (WORD_SIZE+1)'(MEM_SIZE);
        if (req_size_i == 2'b11) err = 2'b11;
        else if (misal)          err = 2'b01;
        else if (oor)            err = 2'b10;
        else                     err = 2'b00;
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < 4; i++)
            raw[8*i +: 8] = mem[ea[AW-1:0] + AW'(i)];
    end

    always_comb begin
        ld = '0;
        unique case (req_size_i)
            2'b00: begin
                ld      = {WORD_SIZE{raw[7] & ~req_unsigned_i}};
                ld[7:0] = raw[7:0];
            end
            2'b01: begin
                ld       = {WORD_SIZE{raw[15] & ~req_unsigned_i}};
                ld[15:0] = raw[15:0];
            end
            2'b10: begin
                ld       = {WORD_SIZE{raw[31] & ~req_unsigned_i}};
                ld[31:0] = raw;
            end
            default: ld = '0;
        endcase
        res_rdata = (err == 2'b00 && !req_write_i) ? ld : '0;
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_write_i && err == 2'b00) begin
            for (int i = 0; i < 4; i++)
                if (2'(i) <= nb_m1)
                    mem[ea[AW-1:0] + AW'(i)] <= wdata_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state != WAIT);
        resp_valid_o = (state == RESP);
    end

    // Result is captured at acceptance (so the load sees memory as of
    // that edge) but only becomes visible when the response is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o    <= '0;
            resp_err_o <= 2'b00;
            pend_rdata <= '0;
            pend_err   <= 2'b00;
        end else begin
            if (accept) begin
                pend_rdata <= res_rdata;
                pend_err   <= err;
            end
            if (accept && LATENCY == 1) begin
                rdata_o    <= res_rdata;
                resp_err_o <= err;
            end else if (wait_done) begin
                rdata_o    <= pend_rdata;
                resp_err_o <= pend_err;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl at latencies 1, 3 and 4.
// Expected values are hand-computed little-endian memory images.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4;
    logic        v1, v3, v4;
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] base, off, wd;

    logic        rdy1, rv1, rdy3, rv3, rdy4, rv4;
    logic [31:0] rd1, rd3, rd4;
    logic [1:0]  er1, er3, er4;

    int total = 0;
    int bad   = 0;

    data_mem_ctrl #(.WORD_SIZE(32), .MEM_SIZE(1024), .LATENCY(1)) d1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
        .req_write_i(wr), .req_size_i(sz), .req_unsigned_i(uns),
        .addr_base_i(base), .addr_offset_i(off), .wdata_i(wd),
        .resp_valid_o(rv1), .rdata_o(rd1), .resp_err_o(er1)
    );

    data_mem_ctrl #(.WORD_SIZE(32), .MEM_SIZE(1024), .LATENCY(3)) d3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_ready_o(rdy3),
        .req_write_i(wr), .req_size_i(sz), .req_unsigned_i(uns),
        .addr_base_i(base), .addr_offset_i(off), .wdata_i(wd),
        .resp_valid_o(rv3), .rdata_o(rd3), .resp_err_o(er3)
    );

    data_mem_ctrl #(.WORD_SIZE(32), .MEM_SIZE(1024), .LATENCY(4)) d4 (
        .clk_i(clk), .rst_i(rst4), .req_valid_i(v4), .req_ready_o(rdy4),
        .req_write_i(wr), .req_size_i(sz), .req_unsigned_i(uns),
        .addr_base_i(base), .addr_offset_i(off), .wdata_i(wd),
        .resp_valid_o(rv4), .rdata_o(rd4), .resp_err_o(er4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setreq(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] b, input logic [31:0] o,
                          input logic [31:0] d);
        wr = w; sz = s; uns = u; base = b; off = o; wd = d;
    endtask

    task automatic t1(input string tag, input logic w, input logic [1:0] s,
                      input logic u, input logic [31:0] b,
                      input logic [31:0] o, input logic [31:0] d,
                      input logic [31:0] xr, input logic [1:0] xe);
        @(negedge clk);
        setreq(w, s, u, b, o, d);
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        setreq(~w, ~s, ~u, ~b, ~o, ~d);
        check({tag, "/v"}, 32'(rv1), 32'd1);
        check({tag, "/d"}, rd1, xr);
        check({tag, "/e"}, 32'(er1), 32'(xe));
    endtask

    task automatic req4(input string tag, input logic w, input logic [1:0] s,
                        input logic [31:0] b, input logic [31:0] d,
                        input logic [31:0] xr, input logic [1:0] xe);
        int n;
        @(negedge clk);
        setreq(w, s, 1'b0, b, 32'h0, d);
        v4 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            v4 = 1'b0;
            n++;
        end while (!rv4 && n < 10);
        check({tag, "/lat"}, 32'(n), 32'd4);
        check({tag, "/d"}, rd4, xr);
        check({tag, "/e"}, 32'(er4), 32'(xe));
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'h0F1E2D3C + 32'(k) * 32'h11111111;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; rst4 = 1'b1;
        v1 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        setreq(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;

        check("rst/rdy", 32'(rdy1), 32'd1);
        check("rst/v",   32'(rv1),  32'd0);
        check("rst/d",   rd1,       32'h0);
        check("rst/e",   32'(er1),  32'd0);
        check("rst/rdy3", 32'(rdy3), 32'd1);

        t1("sw",    1, 2'b10, 0, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0, 2'b00);
        t1("lw",    0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 2'b00);
        t1("lbu",   0, 2'b00, 1, 32'h107, 32'h0, 32'h0, 32'h000000DE, 2'b00);
        t1("lb",    0, 2'b00, 0, 32'h107, 32'h0, 32'h0, 32'hFFFFFFDE, 2'b00);
        t1("lhu",   0, 2'b01, 1, 32'h104, 32'h0, 32'h0, 32'h0000BEEF, 2'b00);
        t1("lh",    0, 2'b01, 0, 32'h104, 32'h0, 32'h0, 32'hFFFFBEEF, 2'b00);
        t1("sb",    1, 2'b00, 0, 32'h104, 32'h0, 32'h12345678, 32'h0, 2'b00);
        t1("lw2",   0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'hDEADBE78, 2'b00);
        t1("sh",    1, 2'b01, 0, 32'h106, 32'h0, 32'hAAAA5555, 32'h0, 2'b00);
        t1("lw3",   0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h5555BE78, 2'b00);
        t1("lwmis", 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 32'h0, 2'b01);
        t1("lw4",   0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 32'h5555BE78, 2'b00);

        @(negedge clk);
        check("hold/v", 32'(rv1), 32'd0);
        check("hold/d", rd1, 32'h5555BE78);

        t1("swtop",  1, 2'b10, 0, 32'h3FC, 32'h0, 32'h01020304, 32'h0, 2'b00);
        t1("swmis",  1, 2'b10, 0, 32'h3FE, 32'h0, 32'hFFFFFFFF, 32'h0, 2'b01);
        t1("lwtop",  0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0, 32'h01020304, 2'b00);
        t1("shmis",  1, 2'b01, 0, 32'h3FF, 32'h0, 32'h0000FFFF, 32'h0, 2'b01);
        t1("lhoor",  0, 2'b01, 0, 32'h400, 32'h0, 32'h0, 32'h0, 2'b10);
        t1("lwoor",  0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 32'h0, 2'b10);
        t1("lwmo",   0, 2'b10, 0, 32'h3FD, 32'h0, 32'h0, 32'h0, 2'b01);
        t1("sz3",    0, 2'b11, 0, 32'h3,   32'h0, 32'h0, 32'h0, 2'b11);
        t1("sz3p",   1, 2'b11, 0, 32'h401, 32'h0, 32'h0, 32'h0, 2'b11);
        t1("sbtop",  1, 2'b00, 0, 32'h3FF, 32'h0, 32'h000000A5, 32'h0, 2'b00);
        t1("lbtop",  0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0, 32'h000000A5, 2'b00);
        t1("lbstop", 0, 2'b00, 0, 32'h3FF, 32'h0, 32'h0, 32'hFFFFFFA5, 2'b00);
        t1("lhtop",  0, 2'b01, 1, 32'h3FE, 32'h0, 32'h0, 32'h0000A502, 2'b00);
        t1("wrap",   1, 2'b10, 0, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 32'h0, 2'b00);
        t1("lwrap",  0, 2'b10, 0, 32'h0, 32'h4, 32'h0, 32'hCAFEF00D, 2'b00);

        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j > 0) begin
                check("strm/v", 32'(rv1), 32'd1);
                check("strm/d", rd1, ((j - 1) % 2 == 1) ? pat((j - 1) / 2) : 32'h0);
            end
            if (j % 2 == 0)
                setreq(1, 2'b10, 0, 32'h200, 32'(4 * (j / 2)), pat(j / 2));
            else
                setreq(0, 2'b10, 0, 32'h200, 32'(4 * (j / 2)), 32'h0);
            v1 = 1'b1;
        end
        @(negedge clk);
        v1 = 1'b0;
        check("strm/v", 32'(rv1), 32'd1);
        check("strm/d", rd1, pat(7));

        @(negedge clk);
        setreq(1, 2'b10, 0, 32'h10, 32'h0, 32'h89ABCDEF);
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        check("l3/rdy1", 32'(rdy3), 32'd0);
        check("l3/v1",   32'(rv3),  32'd0);
        @(negedge clk);
        check("l3/rdy2", 32'(rdy3), 32'd0);
        check("l3/v2",   32'(rv3),  32'd0);
        @(negedge clk);
        check("l3/v3",   32'(rv3),  32'd1);
        check("l3/rdy3", 32'(rdy3), 32'd1);
        check("l3/sd",   rd3,       32'h0);
        setreq(0, 2'b01, 0, 32'h12, 32'h0, 32'h0);
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        check("b2b/v1", 32'(rv3), 32'd0);
        @(negedge clk);
        check("b2b/v2", 32'(rv3), 32'd0);
        @(negedge clk);
        check("b2b/v3", 32'(rv3), 32'd1);
        check("b2b/d",  rd3, 32'hFFFF89AB);
        setreq(0, 2'b00, 1, 32'h10, 32'h0, 32'h0);
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        check("b2b2/hold", rd3, 32'hFFFF89AB);
        @(negedge clk);
        @(negedge clk);
        check("b2b2/v", 32'(rv3), 32'd1);
        check("b2b2/d", rd3, 32'h000000EF);

        req4("l4err", 0, 2'b11, 32'h3, 32'h0, 32'h0, 2'b11);
        @(negedge clk);
        setreq(1, 2'b10, 0, 32'h20, 32'h0, 32'h11223344);
        v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        check("l4/wait", 32'(rdy4), 32'd0);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("l4rst/rdy", 32'(rdy4), 32'd1);
        check("l4rst/v",   32'(rv4),  32'd0);
        check("l4rst/d",   rd4,       32'h0);
        check("l4rst/e",   32'(er4),  32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv4) seen++;
        end
        check("l4rst/nopulse", 32'(seen), 32'd0);
        req4("l4lw", 0, 2'b10, 32'h20, 32'h0, 32'h11223344, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
